// File: rtl/apb_master_pkg.sv
// Shared types for the APB request master and the bridges built around it.
package apb_master_pkg;

    // Transfer sequencing states; one APB transfer runs IDLE -> SETUP -> ACCESS -> RESP.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    // Widest data path any APB master in the cluster supports.
    // Narrower masters use the low DATA_WIDTH bits of rdata.
    localparam int APB_MAX_DATA_WIDTH = 64;

    // Response bundle handed back to the requester.
    typedef struct packed {
        logic [APB_MAX_DATA_WIDTH-1:0] rdata;
        logic                          err;
        logic                          timeout;
    } rsp_t;

    // Number of byte-offset address bits covered by one data word.
    function automatic int addr_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Counts ACCESS wait cycles and flags the cycle that reaches the abort limit.
module apb_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int            CW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST  = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_count;

    // Wait-cycle counter: cleared per transfer, saturates at the limit instead of wrapping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LIMIT)) begin
            r_count <= r_count + CW'(1);
        end
    end

    // Expired in the wait cycle whose increment brings the count to the limit.
    assign o_expired = i_enable && (r_count >= LAST);

endmodule

// File: rtl/apb_req_master.sv
// APB3 initiator: turns one valid/ready request into one SETUP+ACCESS transfer
// and returns the result on a valid/ready response channel.
module apb_req_master
    import apb_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic                  req_write_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  rsp_timeout_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic                  pwrite_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    output logic                  psel_o,
    output logic                  penable_o,
    input  logic [DATA_WIDTH-1:0] prdata_i,
    input  logic                  pready_i,
    input  logic                  pslverr_i
);

    localparam int ADDR_LSB = addr_lsb(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        ~((ADDR_WIDTH'(1) << ADDR_LSB) - ADDR_WIDTH'(1));

    state_e                r_state;
    state_e                w_state_next;
    logic [ADDR_WIDTH-1:0] r_paddr,       w_paddr_next;
    logic                  r_pwrite,      w_pwrite_next;
    logic [DATA_WIDTH-1:0] r_pwdata,      w_pwdata_next;
    logic                  r_psel,        w_psel_next;
    logic                  r_penable,     w_penable_next;
    logic                  r_rsp_valid,   w_rsp_valid_next;
    logic [DATA_WIDTH-1:0] r_rsp_rdata,   w_rsp_rdata_next;
    logic                  r_rsp_err,     w_rsp_err_next;
    logic                  r_rsp_timeout, w_rsp_timeout_next;
    logic                  w_expired;

    // Optional wait-cycle watchdog; without it a transfer waits for pready forever.
    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            logic w_tmo_clear;
            logic w_tmo_enable;
            assign w_tmo_clear  = (r_state == IDLE) && req_valid_i;
            assign w_tmo_enable = (r_state == ACCESS) && !pready_i;
            apb_timeout_cnt #(
                .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
            ) u_timeout_cnt (
                .clk_i     (clk_i),
                .rst_ni    (rst_ni),
                .i_clear   (w_tmo_clear),
                .i_enable  (w_tmo_enable),
                .o_expired (w_expired)
            );
        end else begin : g_no_timeout
            assign w_expired = 1'b0;
        end
    endgenerate

    // Next state and next values of every registered output; hold by default.
    always_comb begin
        w_state_next       = r_state;
        w_paddr_next       = r_paddr;
        w_pwrite_next      = r_pwrite;
        w_pwdata_next      = r_pwdata;
        w_psel_next        = r_psel;
        w_penable_next     = r_penable;
        w_rsp_valid_next   = r_rsp_valid;
        w_rsp_rdata_next   = r_rsp_rdata;
        w_rsp_err_next     = r_rsp_err;
        w_rsp_timeout_next = r_rsp_timeout;
        unique case (r_state)
            IDLE: begin
                if (req_valid_i) begin
                    w_paddr_next   = req_addr_i & ALIGN_MASK;
                    w_pwrite_next  = req_write_i;
                    w_pwdata_next  = req_wdata_i;
                    w_psel_next    = 1'b1;
                    w_penable_next = 1'b0;
                    w_state_next   = SETUP;
                end
            end
            SETUP: begin
                w_penable_next = 1'b1;
                w_state_next   = ACCESS;
            end
            ACCESS: begin
                if (pready_i) begin
                    w_psel_next        = 1'b0;
                    w_penable_next     = 1'b0;
                    w_rsp_valid_next   = 1'b1;
                    w_rsp_rdata_next   = r_pwrite ? '0 : prdata_i;
                    w_rsp_err_next     = pslverr_i;
                    w_rsp_timeout_next = 1'b0;
                    w_state_next       = RESP;
                end else if (w_expired) begin
                    w_psel_next        = 1'b0;
                    w_penable_next     = 1'b0;
                    w_rsp_valid_next   = 1'b1;
                    w_rsp_rdata_next   = '0;
                    w_rsp_err_next     = 1'b1;
                    w_rsp_timeout_next = 1'b1;
                    w_state_next       = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    w_rsp_valid_next = 1'b0;
                    w_state_next     = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State and output registers; reset clears the bus and drops any pending response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= IDLE;
            r_paddr       <= '0;
            r_pwrite      <= 1'b0;
            r_pwdata      <= '0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_paddr       <= w_paddr_next;
            r_pwrite      <= w_pwrite_next;
            r_pwdata      <= w_pwdata_next;
            r_psel        <= w_psel_next;
            r_penable     <= w_penable_next;
            r_rsp_valid   <= w_rsp_valid_next;
            r_rsp_rdata   <= w_rsp_rdata_next;
            r_rsp_err     <= w_rsp_err_next;
            r_rsp_timeout <= w_rsp_timeout_next;
        end
    end

    assign req_ready_o   = (r_state == IDLE);
    assign paddr_o       = r_paddr;
    assign pwrite_o      = r_pwrite;
    assign pwdata_o      = r_pwdata;
    assign psel_o        = r_psel;
    assign penable_o     = r_penable;
    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_rdata_o   = r_rsp_rdata;
    assign rsp_err_o     = r_rsp_err;
    assign rsp_timeout_o = r_rsp_timeout;

endmodule

// File: tb/tb_apb_req_master.sv
// Directed bench for apb_req_master with a 4-cycle timeout; inputs change and
// outputs are sampled on the falling clock edge.
module tb_apb_req_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        req_write = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic        psel;
    logic        penable;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;

    int total = 0;
    int bad = 0;

    apb_req_master #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_addr_i    (req_addr),
        .req_write_i   (req_write),
        .req_wdata_i   (req_wdata),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_rdata_o   (rsp_rdata),
        .rsp_err_o     (rsp_err),
        .rsp_timeout_o (rsp_timeout),
        .paddr_o       (paddr),
        .pwrite_o      (pwrite),
        .pwdata_o      (pwdata),
        .psel_o        (psel),
        .penable_o     (penable),
        .prdata_i      (prdata),
        .pready_i      (pready),
        .pslverr_i     (pslverr)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (psel !== 1'b0) begin bad++; $display("[TB] FAIL rst_psel got=%0h exp=0", psel); end
        total++; if (penable !== 1'b0) begin bad++; $display("[TB] FAIL rst_penable got=%0h exp=0", penable); end
        total++; if (paddr !== 32'h0) begin bad++; $display("[TB] FAIL rst_paddr got=%0h exp=0", paddr); end
        total++; if (pwdata !== 32'h0) begin bad++; $display("[TB] FAIL rst_pwdata got=%0h exp=0", pwdata); end
        total++; if (pwrite !== 1'b0) begin bad++; $display("[TB] FAIL rst_pwrite got=%0h exp=0", pwrite); end
        total++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b000) begin bad++; $display("[TB] FAIL rst_rsp_flags got=%0b exp=000", {rsp_valid, rsp_err, rsp_timeout}); end
        total++; if (rsp_rdata !== 32'h0) begin bad++; $display("[TB] FAIL rst_rsp_rdata got=%0h exp=0", rsp_rdata); end
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_req_ready got=%0h exp=1", req_ready); end
    endtask

    task automatic test_read_zero_wait();
        total++; if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL rd_req_ready got=%0h exp=1", req_ready); end
        req_valid = 1'b1; req_addr = 32'h0000_0008; req_write = 1'b0; req_wdata = 32'h0;
        @(negedge clk);
        req_valid = 1'b0;
        total++; if ({psel, penable} !== 2'b10) begin bad++; $display("[TB] FAIL rd_setup_sel_en got=%0b exp=10", {psel, penable}); end
        total++; if (paddr !== 32'h0000_0008) begin bad++; $display("[TB] FAIL rd_setup_paddr got=%0h exp=8", paddr); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("[TB] FAIL rd_setup_req_ready got=%0h exp=0", req_ready); end
        @(negedge clk);
        total++; if ({psel, penable} !== 2'b11) begin bad++; $display("[TB] FAIL rd_access_sel_en got=%0b exp=11", {psel, penable}); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL rd_access_rsp_valid got=%0h exp=0", rsp_valid); end
        pready = 1'b1; prdata = 32'hDEAD_BEEF;
        @(negedge clk);
        pready = 1'b0; prdata = 32'h0;
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("[TB] FAIL rd_rsp_valid got=%0h exp=1", rsp_valid); end
        total++; if (rsp_rdata !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL rd_rsp_rdata got=%0h exp=deadbeef", rsp_rdata); end
        total++; if ({rsp_err, rsp_timeout} !== 2'b00) begin bad++; $display("[TB] FAIL rd_rsp_err got=%0b exp=00", {rsp_err, rsp_timeout}); end
        total++; if ({psel, penable} !== 2'b00) begin bad++; $display("[TB] FAIL rd_resp_sel_en got=%0b exp=00", {psel, penable}); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        total++; if ({rsp_valid, req_ready} !== 2'b01) begin bad++; $display("[TB] FAIL rd_done_valid_ready got=%0b exp=01", {rsp_valid, req_ready}); end
    endtask

    task automatic test_write_wait();
        req_valid = 1'b1; req_addr = 32'h0000_0014; req_write = 1'b1; req_wdata = 32'h1234_5678;
        @(negedge clk);
        req_valid = 1'b0; req_wdata = 32'hFFFF_FFFF; req_addr = 32'hFFFF_FFFF; req_write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++; if ({psel, penable, pwrite} !== 3'b111) begin bad++; $display("[TB] FAIL wr_access%0d_ctl got=%0b exp=111", i, {psel, penable, pwrite}); end
            total++; if ({paddr, pwdata} !== {32'h0000_0014, 32'h1234_5678}) begin bad++; $display("[TB] FAIL wr_access%0d_addr_data got=%0h/%0h exp=14/12345678", i, paddr, pwdata); end
            total++; if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL wr_access%0d_rsp_valid got=%0h exp=0", i, rsp_valid); end
            pready = (i == 3); prdata = 32'hCAFE_0000;
        end
        @(negedge clk);
        pready = 1'b0; prdata = 32'h0;
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("[TB] FAIL wr_rsp_valid got=%0h exp=1", rsp_valid); end
        total++; if (rsp_rdata !== 32'h0) begin bad++; $display("[TB] FAIL wr_rsp_rdata got=%0h exp=0", rsp_rdata); end
        total++; if ({rsp_err, rsp_timeout} !== 2'b00) begin bad++; $display("[TB] FAIL wr_rsp_err got=%0b exp=00", {rsp_err, rsp_timeout}); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_slave_error();
        req_valid = 1'b1; req_addr = 32'h0000_0007; req_write = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        total++; if (paddr !== 32'h0000_0004) begin bad++; $display("[TB] FAIL err_paddr_align got=%0h exp=4", paddr); end
        total++; if (pwrite !== 1'b0) begin bad++; $display("[TB] FAIL err_pwrite got=%0h exp=0", pwrite); end
        @(negedge clk);
        pready = 1'b1; pslverr = 1'b1; prdata = 32'hAAAA_5555;
        @(negedge clk);
        pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
        total++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b110) begin bad++; $display("[TB] FAIL err_rsp_flags got=%0b exp=110", {rsp_valid, rsp_err, rsp_timeout}); end
        total++; if (rsp_rdata !== 32'hAAAA_5555) begin bad++; $display("[TB] FAIL err_rsp_rdata got=%0h exp=aaaa5555", rsp_rdata); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_timeout(input logic readyLast);
        req_valid = 1'b1; req_addr = 32'h0000_0020; req_write = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++; if ({psel, penable, rsp_valid} !== 3'b110) begin bad++; $display("[TB] FAIL tmo%0d_access%0d got=%0b exp=110", readyLast, i, {psel, penable, rsp_valid}); end
            pready = readyLast && (i == 3);
            pslverr = !pready;
            prdata = pready ? 32'h0000_5A5A : 32'h0000_0055;
        end
        @(negedge clk);
        pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
        total++; if ({psel, penable, rsp_valid} !== 3'b001) begin bad++; $display("[TB] FAIL tmo%0d_resp got=%0b exp=001", readyLast, {psel, penable, rsp_valid}); end
        if (readyLast) begin
            total++; if ({rsp_err, rsp_timeout} !== 2'b00) begin bad++; $display("[TB] FAIL tmo_last_flags got=%0b exp=00", {rsp_err, rsp_timeout}); end
            total++; if (rsp_rdata !== 32'h0000_5A5A) begin bad++; $display("[TB] FAIL tmo_last_rdata got=%0h exp=5a5a", rsp_rdata); end
        end else begin
            total++; if ({rsp_err, rsp_timeout} !== 2'b11) begin bad++; $display("[TB] FAIL tmo_flags got=%0b exp=11", {rsp_err, rsp_timeout}); end
            total++; if (rsp_rdata !== 32'h0) begin bad++; $display("[TB] FAIL tmo_rdata got=%0h exp=0", rsp_rdata); end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1; req_addr = 32'h0000_0040; req_write = 1'b0;
        @(negedge clk);
        req_addr = 32'h0000_0044;
        @(negedge clk);
        pready = 1'b1; prdata = 32'h0102_0304;
        @(negedge clk);
        pready = 1'b0; prdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            total++; if ({rsp_valid, req_ready, psel} !== 3'b100) begin bad++; $display("[TB] FAIL bp%0d_valid_ready got=%0b exp=100", i, {rsp_valid, req_ready, psel}); end
            total++; if (rsp_rdata !== 32'h0102_0304) begin bad++; $display("[TB] FAIL bp%0d_rdata got=%0h exp=01020304", i, rsp_rdata); end
            @(negedge clk);
        end
        total++; if (req_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_handshake_req_ready got=%0h exp=0", req_ready); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        total++; if ({rsp_valid, req_ready, psel} !== 3'b010) begin bad++; $display("[TB] FAIL bp_idle got=%0b exp=010", {rsp_valid, req_ready, psel}); end
        @(negedge clk);
        req_valid = 1'b0;
        total++; if ({psel, penable} !== 2'b10) begin bad++; $display("[TB] FAIL bp_next_setup got=%0b exp=10", {psel, penable}); end
        total++; if (paddr !== 32'h0000_0044) begin bad++; $display("[TB] FAIL bp_next_paddr got=%0h exp=44", paddr); end
        @(negedge clk);
        pready = 1'b1; prdata = 32'h0506_0708;
        @(negedge clk);
        pready = 1'b0; prdata = 32'h0;
        total++; if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h0506_0708}) begin bad++; $display("[TB] FAIL bp_next_rsp got=%0b/%0h exp=1/05060708", rsp_valid, rsp_rdata); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        req_valid = 1'b1; req_addr = 32'h0000_0030; req_write = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        total++; if ({psel, penable} !== 2'b11) begin bad++; $display("[TB] FAIL rma_access got=%0b exp=11", {psel, penable}); end
        #2 rst_n = 1'b0;
        #1;
        total++; if ({psel, penable, rsp_valid} !== 3'b000) begin bad++; $display("[TB] FAIL rma_async_drop got=%0b exp=000", {psel, penable, rsp_valid}); end
        total++; if (paddr !== 32'h0) begin bad++; $display("[TB] FAIL rma_paddr got=%0h exp=0", paddr); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if ({req_ready, rsp_valid} !== 2'b10) begin bad++; $display("[TB] FAIL rma_after_release got=%0b exp=10", {req_ready, rsp_valid}); end
        req_valid = 1'b1; req_addr = 32'h0000_0030;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        pready = 1'b1; prdata = 32'h0BAD_F00D;
        @(negedge clk);
        pready = 1'b0; prdata = 32'h0;
        total++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b100) begin bad++; $display("[TB] FAIL rma_new_rsp got=%0b exp=100", {rsp_valid, rsp_err, rsp_timeout}); end
        total++; if (rsp_rdata !== 32'h0BAD_F00D) begin bad++; $display("[TB] FAIL rma_new_rdata got=%0h exp=0badf00d", rsp_rdata); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    // Scenario sequence; every step is a fixed number of cycles so the run always ends.
    initial begin
        test_reset();
        test_read_zero_wait();
        test_write_wait();
        test_slave_error();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_back_to_back();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
